// File: rtl/bresen_line.sv
// Bresenham line rasteriser: emits one linear framebuffer address (y*H_RES+x)
// per unpaused clock from the start endpoint to the end endpoint inclusive.
module bresen_line #(
  parameter int H_RES  = 640,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [2*X_W+2*Y_W-1:0]   positions,
  input  logic                     primSelect,
  input  logic                     stop,
  output logic [ADDR_W-1:0]        address,
  output logic                     lineDone
);

  localparam int E_W = 12;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_prev_sel;
  logic [X_W-1:0]        r_x;
  logic [X_W-1:0]        r_y;
  logic [X_W-1:0]        r_x1;
  logic [X_W-1:0]        r_y1;
  logic signed [E_W-1:0] r_dx;
  logic signed [E_W-1:0] r_dy;
  logic signed [E_W-1:0] r_err;
  logic                  r_sx_neg;
  logic                  r_sy_neg;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_done;

  logic                  w_start;
  logic [X_W-1:0]        w_x0;
  logic [Y_W-1:0]        w_y0;
  logic [X_W-1:0]        w_x1;
  logic [Y_W-1:0]        w_y1;
  logic [X_W-1:0]        w_adx;
  logic [Y_W-1:0]        w_ady;
  logic signed [E_W-1:0] w_e2;
  logic                  w_step_x;
  logic                  w_step_y;
  logic                  w_at_end;
  logic signed [E_W-1:0] w_err_next;
  logic [ADDR_W-1:0]     w_pix_addr;

  assign w_start = primSelect & ~r_prev_sel;

  assign w_x0 = positions[2*X_W+2*Y_W-1 -: X_W];
  assign w_y0 = positions[X_W+2*Y_W-1 -: Y_W];
  assign w_x1 = positions[X_W+Y_W-1 -: X_W];
  assign w_y1 = positions[Y_W-1:0];

  assign w_adx = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
  assign w_ady = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);

  // Both step decisions compare against the same doubled pre-update error.
  assign w_e2       = r_err <<< 1;
  assign w_step_x   = (w_e2 >= r_dy);
  assign w_step_y   = (w_e2 <= r_dx);
  assign w_err_next = r_err + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);
  assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);

  assign w_pix_addr = ADDR_W'(r_y) * ADDR_W'(H_RES) + ADDR_W'(r_x);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_DRAW;
      S_DRAW:  if (!stop && w_at_end) w_state_next = S_DONE;
      S_DONE:  if (w_start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_prev_sel <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_sx_neg   <= 1'b0;
      r_sy_neg   <= 1'b0;
      r_addr     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_prev_sel <= primSelect;
      case (r_state)
        S_LOAD: begin
          r_x      <= w_x0;
          r_y      <= X_W'(w_y0);
          r_x1     <= w_x1;
          r_y1     <= X_W'(w_y1);
          r_dx     <= $signed(E_W'(w_adx));
          r_dy     <= -$signed(E_W'(w_ady));
          r_err    <= $signed(E_W'(w_adx)) - $signed(E_W'(w_ady));
          r_sx_neg <= !(w_x0 < w_x1);
          r_sy_neg <= !(w_y0 < w_y1);
          r_done   <= 1'b0;
        end
        S_DRAW: begin
          if (!stop) begin
            r_addr <= w_pix_addr;
            if (w_at_end) begin
              r_done <= 1'b1;
            end else begin
              r_err <= w_err_next;
              if (w_step_x) r_x <= r_sx_neg ? (r_x - X_W'(1)) : (r_x + X_W'(1));
              if (w_step_y) r_y <= r_sy_neg ? (r_y - X_W'(1)) : (r_y + X_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign address  = r_addr;
  assign lineDone = r_done;

endmodule

// File: tb/tb_bresen_line.sv
// Self-checking bench for bresen_line: a pixel-list model plus a per-cycle
// compare process, and literal expectations for the hand-worked lines.
module tb_bresen_line;

  logic        clk        = 1'b0;
  logic        n_rst      = 1'b0;
  logic [37:0] positions  = '0;
  logic        primSelect = 1'b0;
  logic        stop       = 1'b0;
  logic [18:0] address;
  logic        lineDone;

  bresen_line dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .positions  (positions),
    .primSelect (primSelect),
    .stop       (stop),
    .address    (address),
    .lineDone   (lineDone)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected pixel list of the line currently being drawn.
  int exp_pix [1024];
  int exp_n = 0;

  task automatic gen_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    exp_n = 0;
    for (int guard = 0; guard < 1024; guard++) begin
      exp_pix[exp_n] = y * 640 + x;
      exp_n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Cycle model: a rising select edge while not drawing starts a line; one
  // setup cycle later pixels of the list are emitted one per unpaused cycle.
  logic m_prev  = 1'b0;
  int   m_phase = 0;
  int   m_idx   = 0;
  int   m_addr  = 0;
  logic m_done  = 1'b0;
  int   n_emit  = 0;
  bit   chk_en  = 1'b0;

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      m_prev  <= 1'b0;
      m_phase <= 0;
      m_idx   <= 0;
      m_addr  <= 0;
      m_done  <= 1'b0;
    end else begin
      m_prev <= primSelect;
      case (m_phase)
        0: if (primSelect && !m_prev) m_phase <= 1;
        1: begin
          m_phase <= 2;
          m_done  <= 1'b0;
          m_idx   <= 0;
        end
        default: if (!stop) begin
          m_addr <= exp_pix[m_idx];
          m_idx  <= m_idx + 1;
          n_emit <= n_emit + 1;
          if (m_idx == exp_n - 1) begin
            m_done  <= 1'b1;
            m_phase <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_addr", int'(address), m_addr);
      chk("cyc_done", int'(lineDone), int'(m_done));
    end
  end

  task automatic start_line(input int x0, input int y0, input int x1, input int y1);
    gen_line(x0, y0, x1, y1);
    positions  = {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
    primSelect = 1'b0;
    @(negedge clk);
    primSelect = 1'b1;
  endtask

  task automatic wait_line_done(input int budget);
    int n;
    n = 0;
    while (lineDone !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (lineDone !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(lineDone === 1'b1), 1);
  endtask

  int saved;
  int e0;

  initial begin
    // Full-screen diagonal, started by select held high across reset.
    positions = {10'd0, 9'd0, 10'd640, 9'd480};
    gen_line(0, 0, 640, 480);
    chk("t1_model_n", exp_n, 641);
    chk("t1_model_first", exp_pix[0], 0);
    chk("t1_model_last", exp_pix[640], 307840);
    #1;
    n_rst      = 1'b1;
    primSelect = 1'b1;
    chk_en     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(address), 0);
    chk("rst_done", int'(lineDone), 0);
    e0    = n_emit;
    n_rst = 1'b0;
    repeat (100) @(negedge clk);
    primSelect = 1'b0;
    @(negedge clk);
    primSelect = 1'b1;
    repeat (200) @(negedge clk);
    stop  = 1'b1;
    saved = int'(address);
    repeat (20) begin
      @(negedge clk);
      chk("pause_hold", int'(address), saved);
    end
    stop = 1'b0;
    wait_line_done(1500);
    chk("t1_end_addr", int'(address), 307840);
    chk("t1_end_done", int'(lineDone), 1);
    chk("t1_pixels", n_emit - e0, 641);
    repeat (5) @(negedge clk);
    chk("t1_hold", int'(address), 307840);

    // Shallow line with an ignored second select edge mid-line.
    start_line(0, 0, 30, 15);
    chk("t2_model_n", exp_n, 31);
    chk("t2_model_p1", exp_pix[1], 641);
    chk("t2_model_p2", exp_pix[2], 642);
    chk("t2_model_last", exp_pix[30], 9630);
    e0 = n_emit;
    repeat (8) @(negedge clk);
    primSelect = 1'b0;
    positions  = {10'd5, 9'd5, 10'd6, 9'd6};
    @(negedge clk);
    primSelect = 1'b1;
    wait_line_done(200);
    chk("t2_end_addr", int'(address), 9630);
    chk("t2_pixels", n_emit - e0, 31);

    // Horizontal, vertical, reversed diagonal.
    start_line(0, 0, 3, 0);
    chk("h_model_n", exp_n, 4);
    chk("h_model_p1", exp_pix[1], 1);
    chk("h_model_p2", exp_pix[2], 2);
    wait_line_done(50);
    chk("h_end_addr", int'(address), 3);

    start_line(5, 0, 5, 2);
    chk("v_model_n", exp_n, 3);
    chk("v_model_p1", exp_pix[1], 645);
    wait_line_done(50);
    chk("v_end_addr", int'(address), 1285);

    start_line(2, 2, 0, 0);
    chk("d_model_n", exp_n, 3);
    chk("d_model_p0", exp_pix[0], 1282);
    chk("d_model_p1", exp_pix[1], 641);
    wait_line_done(50);
    chk("d_end_addr", int'(address), 0);
    chk("d_end_done", int'(lineDone), 1);

    // Degenerate single-pixel line.
    start_line(100, 50, 100, 50);
    chk("deg_model_n", exp_n, 1);
    e0 = n_emit;
    wait_line_done(50);
    chk("deg_addr", int'(address), 32100);
    chk("deg_done", int'(lineDone), 1);
    chk("deg_pixels", n_emit - e0, 1);

    // Restart from DONE: lineDone drops during setup, new start pixel follows.
    start_line(10, 1, 12, 1);
    @(negedge clk);
    chk("rs_done_k", int'(lineDone), 1);
    @(negedge clk);
    chk("rs_done_load", int'(lineDone), 0);
    chk("rs_addr_load", int'(address), 32100);
    @(negedge clk);
    chk("rs_first", int'(address), 650);
    wait_line_done(50);
    chk("rs_end_addr", int'(address), 652);

    // Asynchronous reset in the middle of a long line.
    start_line(0, 0, 640, 480);
    repeat (50) @(negedge clk);
    #2;
    n_rst = 1'b1;
    #1;
    chk("mr_addr", int'(address), 0);
    chk("mr_done", int'(lineDone), 0);
    primSelect = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("mr_quiet", int'(address), 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
